spi_param_fifo: RTL and testbench

SPI_PARAM_FIFO -- requirements
Module: spi_param_fifo

---
 rtl/spi_param_fifo.sv | 113 +++++++++++
 tb/tb_spi_param_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_param_fifo.sv
// Parameterised synchronous FIFO with registered read port,
// occupancy level, threshold flags and sticky error flags.
module spi_param_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int POINTER_WIDTH = 6
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     clear,
  input  logic                     flag_clr,
  input  logic                     wen,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     ren,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     rvalid,
  output logic [POINTER_WIDTH:0]   level,
  input  logic [POINTER_WIDTH:0]   af_th,
  input  logic [POINTER_WIDTH:0]   ae_th,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH = 2 ** POINTER_WIDTH;
  localparam int PW1   = POINTER_WIDTH + 1;
  localparam logic [POINTER_WIDTH:0] DEPTH_L = PW1'(DEPTH);
  localparam logic [POINTER_WIDTH:0] PONE =
    {{POINTER_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [POINTER_WIDTH:0] wptr_q, wptr_d;
  logic [POINTER_WIDTH:0] rptr_q, rptr_d;
  logic [POINTER_WIDTH:0] level_q, level_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic                   ovf_q, ovf_d;
  logic                   udf_q, udf_d;
  logic                   rd_acc, wr_acc;

  assign full         = (level_q == DEPTH_L);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= af_th);
  assign almost_empty = (level_q <= ae_th);
  assign level        = level_q;
  assign rdata        = rdata_q;
  assign rvalid       = rvalid_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A full FIFO still takes a write when a read frees a slot.
  assign rd_acc = ren && !empty && !clear;
  assign wr_acc = wen && (!full || rd_acc) && !clear;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    level_d  = level_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PONE;
      if (rd_acc) begin
        rptr_d   = rptr_q + PONE;
        rdata_d  = mem_q[rptr_q[POINTER_WIDTH-1:0]];
        rvalid_d = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + PONE;
        2'b01:   level_d = level_q - PONE;
        default: level_d = level_q;
      endcase
      ovf_d = (ovf_q && !flag_clr) || (wen && !wr_acc);
      udf_d = (udf_q && !flag_clr) || (ren && !rd_acc);
    end
  end

  always_ff @(posedge pclk) begin
    if (wr_acc && !preset)
      mem_q[wptr_q[POINTER_WIDTH-1:0]] <= wdata;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

endmodule

// File: tb/tb_spi_param_fifo.sv
// Bench for spi_param_fifo: queue reference model, directed
// scenarios, then randomized traffic; small-depth wrap instance.
module tb_spi_param_fifo;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        clear = 1'b0, flag_clr = 1'b0;
  logic        wen = 1'b0, ren = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic [6:0]  level;
  logic [6:0]  af_th = 7'd60, ae_th = 7'd2;
  logic        full, empty, almost_full, almost_empty;
  logic        overflow, underflow;

  logic        s_wen = 1'b0, s_ren = 1'b0;
  logic [7:0]  s_wdata = '0;
  logic [7:0]  s_rdata;
  logic        s_rvalid;
  logic [2:0]  s_level;
  logic        s_full, s_empty, s_af, s_ae, s_ovf, s_udf;

  int total = 0;
  int bad = 0;

  logic [31:0] mq[$];
  logic [31:0] m_rd = '0;
  bit          m_rv, m_ovf, m_udf;

  always #5 pclk = ~pclk;

  spi_param_fifo dut (
    .pclk(pclk), .preset(preset), .clear(clear),
    .flag_clr(flag_clr), .wen(wen), .wdata(wdata),
    .ren(ren), .rdata(rdata), .rvalid(rvalid),
    .level(level), .af_th(af_th), .ae_th(ae_th),
    .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  spi_param_fifo #(.DATA_WIDTH(8), .POINTER_WIDTH(2)) dut_s (
    .pclk(pclk), .preset(preset), .clear(1'b0),
    .flag_clr(1'b0), .wen(s_wen), .wdata(s_wdata),
    .ren(s_ren), .rdata(s_rdata), .rvalid(s_rvalid),
    .level(s_level), .af_th(3'd3), .ae_th(3'd1),
    .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae),
    .overflow(s_ovf), .underflow(s_udf)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a plain queue of words plus sticky bits.
  task automatic model(input bit w, input logic [31:0] wd,
                       input bit r, input bit cl, input bit fc,
                       input bit rst);
    bit rok, wok;
    if (rst) begin
      mq.delete(); m_rd = '0; m_rv = 0; m_ovf = 0; m_udf = 0;
    end else if (cl) begin
      mq.delete(); m_rv = 0; m_ovf = 0; m_udf = 0;
    end else begin
      rok = r && (mq.size() > 0);
      wok = w && (mq.size() < 64 || rok);
      m_rv = rok;
      if (rok) m_rd = mq.pop_front();
      if (wok) mq.push_back(wd);
      m_ovf = (m_ovf && !fc) || (w && !wok);
      m_udf = (m_udf && !fc) || (r && !rok);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("level", level, n);
    chk("full", full, n == 64);
    chk("empty", empty, n == 0);
    chk("almost_full", almost_full, n >= int'(af_th));
    chk("almost_empty", almost_empty, n <= int'(ae_th));
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_udf);
    chk("rvalid", rvalid, m_rv);
    chk("rdata", rdata, m_rd);
  endtask

  task automatic step(input bit w = 0, input logic [31:0] wd = '0,
                      input bit r = 0, input bit cl = 0,
                      input bit fc = 0, input bit rst = 0);
    wen = w; wdata = wd; ren = r;
    clear = cl; flag_clr = fc; preset = rst;
    model(w, wd, r, cl, fc, rst);
    @(posedge pclk);
    #1;
    check_all();
  endtask

  initial begin
    step(.rst(1));
    step(.rst(1));
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_empty", empty, 1);
    af_th = 7'd60; ae_th = 7'd4;

    // Fill then drain in order; threshold edges on the way.
    for (int i = 0; i < 64; i++) begin
      step(.w(1), .wd(i));
      if (i == 4) chk("ae_off_at5", almost_empty, 0);
      if (i == 3) chk("ae_on_at4", almost_empty, 1);
      if (i == 58) chk("af_off_at59", almost_full, 0);
      if (i == 59) chk("af_on_at60", almost_full, 1);
    end
    chk("full64", full, 1);
    for (int i = 0; i < 64; i++) begin
      step(.r(1));
      chk("seq_rdata", rdata, i);
      chk("seq_rvalid", rvalid, 1);
    end
    chk("drained_empty", empty, 1);
    chk("no_ovf", overflow, 0);
    chk("no_udf", underflow, 0);

    // Overflow on full, then simultaneous write/read at full.
    for (int i = 0; i < 64; i++) step(.w(1), .wd(32'h100 + i));
    step(.w(1), .wd(32'hdead));
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, 64);
    step();
    step(.r(1));
    chk("ovf_first", rdata, 32'h100);
    step(.w(1), .wd(32'h200));
    step(.fc(1));
    chk("ovf_clr", overflow, 0);
    step(.w(1), .wd(32'h201), .r(1));
    chk("wr_at_full", level, 64);
    chk("no_reovf", overflow, 0);
    step(.r(1));
    chk("wr_at_full_rd", rdata, 32'h102);

    // Underflow and empty-side simultaneous access.
    step(.cl(1));
    step(.r(1));
    chk("udf_set", underflow, 1);
    chk("udf_rvalid", rvalid, 0);
    step(.w(1), .wd(32'h55), .r(1));
    chk("wr_on_empty", level, 1);
    chk("udf_stay", underflow, 1);
    step(.fc(1));
    chk("udf_clr", underflow, 0);
    step(.r(1));
    chk("wr_on_empty_rd", rdata, 32'h55);

    // Clear and reset mid-operation.
    for (int i = 0; i < 10; i++) step(.w(1), .wd(32'h300 + i));
    step(.w(1), .wd(32'hbeef), .cl(1));
    chk("clr_level", level, 0);
    chk("clr_empty", empty, 1);
    for (int i = 0; i < 10; i++) step(.w(1), .wd(32'h400 + i));
    step(.w(1), .wd(32'h1), .r(1), .rst(1));
    chk("rst_level", level, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rvalid, 0);

    // Depth-4 instance: pointers wrap across rounds.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) begin
        s_wen = 1; s_wdata = 8'(r * 3 + i);
        step();
        s_wen = 0;
      end
      chk("s_level3", s_level, 3);
      for (int i = 0; i < 3; i++) begin
        s_ren = 1;
        step();
        s_ren = 0;
        chk("s_rvalid", s_rvalid, 1);
        chk("s_rdata", s_rdata, 8'(r * 3 + i));
      end
      chk("s_level0", s_level, 0);
      chk("s_empty", s_empty, 1);
    end
    chk("s_no_err", {s_ovf, s_udf}, 0);

    // Randomized traffic with shifting read/write bias.
    begin
      int pw, pr;
      pw = 50; pr = 50;
      for (int c = 0; c < 4000; c++) begin
        if (c % 400 == 0) begin
          pw = $urandom_range(10, 90);
          pr = $urandom_range(10, 90);
        end
        if (c % 150 == 0) begin
          af_th = 7'($urandom_range(0, 64));
          ae_th = 7'($urandom_range(0, 64));
        end
        step(.w($urandom_range(0, 99) < pw), .wd($urandom),
             .r($urandom_range(0, 99) < pr),
             .cl($urandom_range(0, 99) == 0),
             .fc($urandom_range(0, 39) == 0),
             .rst($urandom_range(0, 399) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
